// File: rtl/dtb_pkg.sv
// dtb_pkg: shared types for trb_trigger_ctrl. The field widths are derived from the P_* sizes,
// so the module parameters must keep their defaults unless these sizes change with them.
package dtb_pkg;
    localparam int P_WIDTH      = 32;
    localparam int P_DEPTH      = 32;
    localparam int P_DELAY_BITS = 2;
    localparam int P_MAX_TRACES = 16;
    localparam int ADDR_BITS    = $clog2(P_DEPTH);
    localparam int POS_BITS     = $clog2(P_WIDTH);
    localparam int TRACE_LOG2   = $clog2(P_MAX_TRACES);
    localparam int TRACE_BITS   = (TRACE_LOG2 > 0) ? $clog2(TRACE_LOG2 + 1) : 1;

    typedef enum logic [1:0] {
        trace_mode,
        rw_stream_mode,
        w_stream_mode,
        r_stream_mode
    } trg_mode_t;

    typedef struct packed {
        trg_mode_t               mode;
        logic [TRACE_BITS-1:0]   trg_num_traces;
        logic [P_DELAY_BITS-1:0] trg_delay;
    } control_t;

    typedef struct packed {
        logic                 trg_event;
        logic [POS_BITS-1:0]  event_pos;
        logic [ADDR_BITS-1:0] event_addr;
    } status_t;

    localparam control_t CONTROL_DEFAULT = '{mode: trace_mode, trg_num_traces: '0, trg_delay: '0};
    localparam status_t  STATUS_DEFAULT  = '0;

    function automatic logic [TRACE_BITS-1:0] clamp_traces(input logic [TRACE_BITS-1:0] n, input int unsigned lim);
        return (n > TRACE_BITS'(lim)) ? TRACE_BITS'(lim) : n;
    endfunction
endpackage

// File: rtl/trb_lsb_enc.sv
// trb_lsb_enc: index of the lowest set bit of vec_i; found_o flags any bit set.
module trb_lsb_enc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         vec_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     found_o
);
    localparam int IW = $clog2(WIDTH);

    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (vec_i[i]) idx_o = IW'(i);
    end

    assign found_o = |vec_i;
endmodule

// File: rtl/trb_trigger_ctrl.sv
// trb_trigger_ctrl: segmented trigger capture and streaming write controller for a sample buffer.
// Define TRB_TRG_EDGE_EN for per-lane rising-edge triggering (default: level triggering).
module trb_trigger_ctrl
    import dtb_pkg::*;
#(
    parameter int WIDTH      = P_WIDTH,
    parameter int DEPTH      = P_DEPTH,
    parameter int DELAY_BITS = P_DELAY_BITS,
    parameter int MAX_TRACES = P_MAX_TRACES
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  control_t                 control_i,
    input  logic                     arm_i,
    input  logic                     valid_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [WIDTH-1:0]         trg_i,
    output logic                     we_o,
    output logic [$clog2(DEPTH)-1:0] waddr_o,
    output logic [WIDTH-1:0]         wdata_o,
    output status_t                  status_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam int PW  = AW + DELAY_BITS + 2;
    localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_POST = 3'd2, S_DONE = 3'd3, S_STREAM = 3'd4;

    logic [2:0]               state;
    logic                     arm_q;
    control_t                 ctrl_q;
    logic [AW-1:0]            base, off;
    logic [AW:0]              seg_size, post_len, post_cnt;
    logic [PW-1:0]            post_raw;
    logic [WIDTH-1:0]         trg_eff;
    logic [$clog2(WIDTH)-1:0] lsb_idx;
    logic                     lsb_found, start, trig, capture, wr, last_seg, post_hit;

`ifdef TRB_TRG_EDGE_EN
    logic [WIDTH-1:0] trg_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) trg_q <= '0;
        else if (start) trg_q <= '0;
        else if (valid_i) trg_q <= trg_i;

    assign trg_eff = trg_i & ~trg_q;
`else
    assign trg_eff = trg_i;
`endif

    trb_lsb_enc #(.WIDTH(WIDTH)) u_lsb (.vec_i(trg_eff), .idx_o(lsb_idx), .found_o(lsb_found));

    assign seg_size = AW1'(DEPTH) >> clamp_traces(ctrl_q.trg_num_traces, $clog2(MAX_TRACES));
    assign post_raw = ((PW'(ctrl_q.trg_delay) + PW'(1)) * PW'(seg_size)) >> DELAY_BITS;
    assign post_len = (post_raw == '0) ? AW1'(1) : AW1'(post_raw);
    assign start    = (state == S_IDLE) && arm_i && !arm_q;
    assign trig     = valid_i && lsb_found;
    assign capture  = (state == S_ARMED || state == S_POST) && valid_i;
    assign wr       = arm_i && valid_i && (state == S_ARMED || state == S_POST ||
                      (state == S_STREAM && ctrl_q.mode != r_stream_mode));
    assign last_seg = base == AW'(AW1'(DEPTH) - seg_size);
    assign post_hit = (post_cnt + AW1'(1)) == post_len;
    assign busy_o   = state == S_ARMED || state == S_POST || state == S_STREAM;
    assign done_o   = state == S_DONE;

    // arm_q resets high so an arm already asserted at reset release is not taken as an edge
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state    <= S_IDLE;
            arm_q    <= 1'b1;
            ctrl_q   <= CONTROL_DEFAULT;
            status_o <= STATUS_DEFAULT;
            base     <= '0;
            off      <= '0;
            post_cnt <= '0;
            we_o     <= 1'b0;
            waddr_o  <= '0;
            wdata_o  <= '0;
        end else begin
            arm_q <= arm_i;
            we_o  <= wr;
            if (wr) begin
                waddr_o <= base + off;
                wdata_o <= data_i;
                off     <= (state != S_STREAM && off == AW'(seg_size - AW1'(1))) ? '0 : off + AW'(1);
            end
            if (!arm_i) state <= S_IDLE;
            else if (start) begin
                ctrl_q   <= control_i;
                status_o <= STATUS_DEFAULT;
                base     <= '0;
                off      <= '0;
                post_cnt <= '0;
                state    <= (control_i.mode == trace_mode) ? S_ARMED : S_STREAM;
            end else if (capture && (state == S_POST || trig)) begin
                if (state == S_ARMED)
                    status_o <= '{trg_event: 1'b1, event_pos: lsb_idx, event_addr: base + off};
                if (!post_hit) begin
                    post_cnt <= post_cnt + AW1'(1);
                    state    <= S_POST;
                end else begin
                    post_cnt <= '0;
                    if (last_seg) state <= S_DONE;
                    else begin
                        base  <= base + AW'(seg_size);
                        off   <= '0;
                        state <= S_ARMED;
                    end
                end
            end
        end
endmodule

// File: tb/tb_trb_trigger_ctrl.sv
// tb_trb_trigger_ctrl: directed and randomized checks of trb_trigger_ctrl against a segment/offset model.
module tb_trb_trigger_ctrl;
    import dtb_pkg::*;

    localparam int W = 32, D = 32, DB = 2, MT = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    control_t control;
    logic arm = 1'b1, valid = 1'b0;
    logic [W-1:0] data = '0, trg = '0;
    logic we, busy, done;
    logic [4:0] waddr;
    logic [W-1:0] wdata;
    status_t status;

    always #5 clk = ~clk;

    trb_trigger_ctrl #(.WIDTH(W), .DEPTH(D), .DELAY_BITS(DB), .MAX_TRACES(MT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .control_i(control), .arm_i(arm), .valid_i(valid),
        .data_i(data), .trg_i(trg), .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
        .status_o(status), .busy_o(busy), .done_o(done));

    int checks = 0, errors = 0;
    int ph;
    int nseg, seg, post, k, off, left, cnt, m_mode;
    bit arm_prev, e_we, s_evt;
    int e_addr, s_pos, s_addr;
    logic [W-1:0] prev_trg, e_data;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        ph = 0; arm_prev = 1; prev_trg = '0; e_we = 0;
        s_evt = 0; s_pos = 0; s_addr = 0;
    endtask

    task automatic model(input bit a, input bit v, input logic [W-1:0] d, input logic [W-1:0] t);
        logic [W-1:0] eff;
        bit arming;
        int tr;
        arming = 0;
        e_we = 0;
`ifdef TRB_TRG_EDGE_EN
        eff = t & ~prev_trg;
`else
        eff = t;
`endif
        if (!a) ph = 0;
        else if (ph == 0 && !arm_prev) begin
            arming = 1;
            m_mode = int'(control.mode);
            tr = (int'(control.trg_num_traces) > 4) ? 4 : int'(control.trg_num_traces);
            nseg = 1 << tr;
            seg = D / nseg;
            post = ((int'(control.trg_delay) + 1) * seg) >> DB;
            if (post == 0) post = 1;
            ph = (m_mode == 0) ? 1 : 4;
            k = 0; off = 0; cnt = 0; s_evt = 0; s_pos = 0; s_addr = 0;
        end else if (v && (ph == 1 || ph == 2)) begin
            e_we = 1; e_addr = k * seg + off; e_data = d;
            off = (off + 1) % seg;
            if (ph == 1 && eff != 0) begin
                ph = 2; left = post; s_evt = 1; s_addr = e_addr;
                for (int i = W - 1; i >= 0; i--) if (eff[i]) s_pos = i;
            end
            if (ph == 2) begin
                left = left - 1;
                if (left == 0) begin
                    if (k == nseg - 1) ph = 3;
                    else begin k++; off = 0; ph = 1; end
                end
            end
        end else if (v && ph == 4 && m_mode != 3) begin
            e_we = 1; e_addr = cnt % D; e_data = d; cnt++;
        end
        if (arming) prev_trg = '0;
        else if (v) prev_trg = t;
        arm_prev = a;
    endtask

    task automatic check_all();
        chk("we", we, e_we);
        if (e_we) begin
            chk("waddr", waddr, e_addr);
            chk("wdata", wdata, e_data);
        end
        chk("busy", busy, ph == 1 || ph == 2 || ph == 4);
        chk("done", done, ph == 3);
        chk("status", status, {s_evt, 5'(s_pos), 5'(s_addr)});
    endtask

    task automatic cycle(input bit a, input bit v, input logic [W-1:0] d, input logic [W-1:0] t);
        arm = a; valid = v; data = d; trg = t;
        model(a, v, d, t);
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic control_t rand_ctrl();
        control_t c;
        c.mode = trg_mode_t'($urandom_range(0, 1) != 0 ? 0 : $urandom_range(1, 3));
        c.trg_num_traces = TRACE_BITS'($urandom_range(0, 7));
        c.trg_delay = DB'($urandom);
        return c;
    endfunction

    initial begin
        control = '{mode: trace_mode, trg_num_traces: '0, trg_delay: '0};
        model_reset();
        #1;
        check_all();
        #20 rst_n = 1'b1;
        // arm held high across reset release must not start a capture
        repeat (3) cycle(1, 1, $urandom, '1);
        chk("rel_noarm_busy", busy, 0);

        // single segment, delay 3: POST = 32
        cycle(0, 0, 0, 0);
        control = '{mode: trace_mode, trg_num_traces: 3'd0, trg_delay: 2'd3};
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) cycle(1, 1, 32'hA000 + i, i == 5 ? 32'h10 : 32'h0);
        chk("r031_status", status, {1'b1, 5'd4, 5'd5});
        chk("r031_done", done, 1);

        // four segments of 8, POST = 2
        cycle(0, 0, 0, 0);
        control = '{mode: trace_mode, trg_num_traces: 3'd2, trg_delay: 2'd0};
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 300 && ph != 3; i++)
            cycle(1, $urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 5) == 0 ? 32'h1 << $urandom_range(0, 31) : 32'h0);
        chk("r032_done", done, 1);

        // lowest-lane encoding and trigger ignored without valid
        cycle(0, 0, 0, 0);
        control = '{mode: trace_mode, trg_num_traces: 3'd0, trg_delay: 2'd3};
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 32'hFF);
        chk("r033_noevt", status.trg_event, 0);
        cycle(1, 1, 1, 32'h0000_8006);
        chk("r033_pos", status.event_pos, 1);

        // write stream: 40 samples wrap the whole buffer, triggers ignored
        cycle(0, 0, 0, 0);
        control = '{mode: w_stream_mode, trg_num_traces: 3'd1, trg_delay: 2'd2};
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) cycle(1, 1, $urandom, $urandom);
        chk("r034_waddr", waddr, 7);
        chk("r034_evt", status.trg_event, 0);
        cycle(0, 0, 0, 0);
        control = '{mode: r_stream_mode, trg_num_traces: 3'd0, trg_delay: 2'd0};
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(1, 1, $urandom, $urandom);
        cycle(0, 0, 0, 0);
        control = '{mode: rw_stream_mode, trg_num_traces: 3'd0, trg_delay: 2'd0};
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(1, $urandom_range(0, 1) != 0, $urandom, 0);

        // abort mid-POST, status held, re-arm clears
        cycle(0, 0, 0, 0);
        control = '{mode: trace_mode, trg_num_traces: 3'd0, trg_delay: 2'd3};
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, $urandom, 0);
        cycle(1, 1, 32'h55, 32'h4);
        for (int i = 0; i < 5; i++) cycle(1, 1, $urandom, 0);
        cycle(0, 1, 32'h77, 0);
        chk("r035_we", we, 0);
        chk("r035_busy", busy, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, $urandom, '1);
        chk("r035_held", status, {1'b1, 5'd2, 5'd3});
        cycle(1, 0, 0, 0);
        chk("r035_clear", status.trg_event, 0);

        // asynchronous reset while ARMED
        for (int i = 0; i < 4; i++) cycle(1, 1, $urandom, 0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 0);
        check_all();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, 1, $urandom, 0);

        // held trigger lane: exactly one event at the first sample
        cycle(0, 0, 0, 0);
        control = '{mode: trace_mode, trg_num_traces: 3'd0, trg_delay: 2'd3};
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, $urandom, 32'h1);
        chk("r036_evt", status, {1'b1, 5'd0, 5'd0});

        // trace count above log2(MAX_TRACES) is clamped
        cycle(0, 0, 0, 0);
        control = '{mode: trace_mode, trg_num_traces: 3'd7, trg_delay: 2'd1};
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 200 && ph != 3; i++)
            cycle(1, 1, $urandom, $urandom_range(0, 2) == 0 ? $urandom : 32'h0);
        chk("clamp_done", done, 1);

        // randomized sessions; control_i changes while armed must be ignored
        for (int s = 0; s < 8; s++) begin
            int n;
            cycle(0, 0, 0, 0);
            control = rand_ctrl();
            cycle(1, 0, 0, 0);
            n = $urandom_range(20, 150);
            for (int i = 0; i < n; i++) begin
                control = rand_ctrl();
                cycle($urandom_range(0, 40) != 0, $urandom_range(0, 2) != 0, $urandom,
                      $urandom_range(0, 7) == 0 ? $urandom : 32'h0);
            end
        end
        cycle(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
